// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 7-segment scan controller; drives the external ring counter CE,
// tracks the active digit and inserts dead-time blanking. Define LZB_EN for leading-zero blanking.
module disp_scan_ctrl #(
  parameter int   DIGITS    = 4,
  parameter int   PRESC     = 1000,
  parameter int   BLANK_CYC = 50,
  parameter logic ACT_STATE = 1'b0,
  parameter logic SEG_ACT   = 1'b0
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic                       EN,
  input  logic [4*DIGITS-1:0]        DATA,
  input  logic [DIGITS-1:0]          DP,
  output logic                       RING_CE,
  output logic [$clog2(DIGITS)-1:0]  SLOT,
  output logic [DIGITS-1:0]          DIG_EN,
  output logic [7:0]                 SEG
);

  localparam int SW = $clog2(DIGITS);
  localparam int CW = $clog2(PRESC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;

  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0]     CNT_LAST   = CW'(PRESC - 1);
  localparam logic [SW-1:0]     DIG_LAST   = SW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_OFF    = {DIGITS{~ACT_STATE}};
  localparam logic [7:0]        SEG_OFF    = {8{~SEG_ACT}};

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     slot_q, slot_d, slot_inc;
  logic              started_q, started_d;
  logic              ce_q, ce_d;
  logic [DIGITS-1:0] dig_q, dig_d, onehot;
  logic [7:0]        seg_q, seg_d, seg_raw;
  logic [3:0]        nib;
  logic [6:0]        glyph;
  logic              lead_zero;

  // {g,f,e,d,c,b,a}, active high
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef LZB_EN
  // digit blanks when it and every more-significant nibble is zero; dp still shown
  assign lead_zero = (slot_q != '0) && ((DATA >> {slot_q, 2'b00}) == '0);
`else
  assign lead_zero = 1'b0;
`endif

  assign nib      = DATA[{slot_q, 2'b00} +: 4];
  assign glyph    = lead_zero ? 7'h00 : hex7(nib);
  assign seg_raw  = {DP[slot_q], glyph};
  assign slot_inc = (slot_q == DIG_LAST) ? '0 : slot_q + SW'(1);

  always_comb begin
    onehot         = '0;
    onehot[slot_q] = 1'b1;
  end

  // cnt spans the whole slot: BLANK uses 0..BLANK_CYC-1, ON uses BLANK_CYC..PRESC-1
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    started_d = started_q;
    ce_d      = 1'b0;
    dig_d     = dig_q;
    seg_d     = seg_q;
    if (!EN) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dig_d   = DIG_OFF;
      seg_d   = SEG_OFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_BLANK;
          cnt_d     = '0;
          ce_d      = 1'b1;
          slot_d    = started_q ? slot_inc : '0;
          started_d = 1'b1;
          dig_d     = DIG_OFF;
          seg_d     = SEG_OFF;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CW'(1);
          dig_d = DIG_OFF;
          seg_d = SEG_OFF;
          if (cnt_q == BLANK_LAST) begin
            state_d = S_ON;
            dig_d   = ACT_STATE ? onehot : ~onehot;
            seg_d   = SEG_ACT ? seg_raw : ~seg_raw;
          end
        end
        S_ON: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            ce_d    = 1'b1;
            slot_d  = slot_inc;
            dig_d   = DIG_OFF;
            seg_d   = SEG_OFF;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          dig_d   = DIG_OFF;
          seg_d   = SEG_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      slot_q    <= '0;
      started_q <= 1'b0;
      ce_q      <= 1'b0;
      dig_q     <= DIG_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      started_q <= started_d;
      ce_q      <= ce_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
    end
  end

  assign RING_CE = ce_q;
  assign SLOT    = slot_q;
  assign DIG_EN  = dig_q;
  assign SEG     = seg_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed + random scan checks against a slot-arithmetic reference model.
// Build with LZB_EN defined to exercise leading-zero blanking.
module tb_disp_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int PRESC     = 10;
  localparam int BLANK_CYC = 2;

  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        EN  = 1'b1;
  logic [15:0] DATA = 16'h1234;
  logic [3:0]  DP   = 4'h0;
  logic        RING_CE;
  logic [1:0]  SLOT;
  logic [3:0]  DIG_EN;
  logic [7:0]  SEG;

  int nchk = 0;
  int nerr = 0;

  // reference model state: outputs expected after the most recent clock edge
  bit         m_active, m_started, m_ce;
  int         m_slot, m_k, m_ph;
  logic [3:0] m_dig;
  logic [7:0] m_seg;

  disp_scan_ctrl #(
    .DIGITS(DIGITS), .PRESC(PRESC), .BLANK_CYC(BLANK_CYC),
    .ACT_STATE(1'b0), .SEG_ACT(1'b0)
  ) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .DATA(DATA), .DP(DP),
    .RING_CE(RING_CE), .SLOT(SLOT), .DIG_EN(DIG_EN), .SEG(SEG)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [15:0] d, input logic [3:0] p, input int s);
    logic [6:0] g;
    logic [3:0] n;
    bit lead;
    lead = 1'b1;
    for (int i = s; i < DIGITS; i++) if (((d >> (4 * i)) & 16'hF) != 0) lead = 1'b0;
    n = 4'((d >> (4 * s)) & 16'hF);
    g = FONT[n];
`ifdef LZB_EN
    if (s > 0 && lead) g = 7'h00;
`endif
    return ~{p[s], g};
  endfunction

  task automatic model_reset();
    m_active = 0; m_started = 0; m_ce = 0; m_slot = 0; m_k = 0; m_ph = -1;
    m_dig = 4'hF; m_seg = 8'hFF;
  endtask

  // k counts cycles since the scan (re)started; slot boundaries fall on multiples of PRESC
  task automatic model_update(input logic en, input logic [15:0] d, input logic [3:0] p);
    logic [3:0] oh;
    if (!en) begin
      m_active = 0; m_ph = -1; m_ce = 0; m_dig = 4'hF; m_seg = 8'hFF;
    end else begin
      if (!m_active) begin
        m_active = 1; m_k = 0;
        m_slot = m_started ? (m_slot + 1) % DIGITS : 0;
        m_started = 1;
      end else begin
        m_k++;
        if (m_k % PRESC == 0) m_slot = (m_slot + 1) % DIGITS;
      end
      m_ph = m_k % PRESC;
      m_ce = (m_ph == 0);
      if (m_ph < BLANK_CYC) begin
        m_dig = 4'hF; m_seg = 8'hFF;
      end else if (m_ph == BLANK_CYC) begin
        oh = 4'b0001 << m_slot;
        m_dig = ~oh;
        m_seg = ref_seg(d, p, m_slot);
      end
    end
  endtask

  task automatic check_all();
    chk("ce", RING_CE, m_ce);
    chk("slot", SLOT, m_slot);
    chk("dig", DIG_EN, m_dig);
    chk("seg", SEG, m_seg);
    chk("onehot", $countones(~DIG_EN) <= 1, 1);
  endtask

  // called at a falling edge: drive, advance model one edge, check at next falling edge
  task automatic step(input logic en, input logic [15:0] d, input logic [3:0] p);
    EN = en; DATA = d; DP = p;
    model_update(en, d, p);
    @(negedge CLK);
    check_all();
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic run_to(input int s, input int ph, input logic [15:0] d, input logic [3:0] p);
    int n;
    n = 0;
    do begin
      step(1'b1, d, p);
      n++;
    end while (!(m_slot == s && m_ph == ph) && n < 200);
    if (n >= 200) chk("run_to_timeout", 0, 1);
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    return d;
  endfunction

  initial begin
    int n, lit;
    logic [15:0] d;
    logic [3:0]  p;
    logic        en;

    // reset held with EN=1
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_dig", DIG_EN, 4'b1111);
    chk("rst_seg", SEG, 8'hFF);
    chk("rst_ce", RING_CE, 0);
    check_all();

    CLR = 1'b0;
    step(1'b1, 16'h1234, 4'h0);
    chk("first_ce", RING_CE, 1);
    chk("first_slot", SLOT, 0);
    step(1'b1, 16'h1234, 4'h0);
    chk("first_blank", DIG_EN, 4'b1111);
    step(1'b1, 16'h1234, 4'h0);
    chk("first_dig", DIG_EN, 4'b1110);
    chk("first_seg", SEG, 8'b1001_1001);

    // period and lit time per slot, measured from the DUT's own pulses
    for (int s = 0; s < 5; s++) begin
      n = 0; lit = 0;
      do begin
        step(1'b1, 16'h1234, 4'h0);
        n++;
        if (DIG_EN != 4'hF) lit++;
      end while (!RING_CE && n < 50);
      if (s > 0) begin
        chk("period", n, PRESC);
        chk("lit_cycles", lit, PRESC - BLANK_CYC);
      end
      chk("seq_slot", SLOT, (s + 1) % DIGITS);
    end

    // EN gap during slot 2 ON
    run_to(2, BLANK_CYC + 3, 16'h1234, 4'h0);
    step(1'b0, 16'h1234, 4'h0);
    chk("gap_dig", DIG_EN, 4'hF);
    chk("gap_seg", SEG, 8'hFF);
    chk("gap_ce", RING_CE, 0);
    step(1'b0, 16'h1234, 4'h0);
    step(1'b1, 16'h1234, 4'h0);
    chk("reen_ce", RING_CE, 1);
    chk("reen_slot", SLOT, 3);

    // data change mid-slot is ignored until the digit comes round again
    run_to(0, BLANK_CYC + 2, 16'h1234, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h1237, 4'h0);
    chk("hold_seg", SEG, 8'h99);
    run_to(0, BLANK_CYC, 16'h1237, 4'h0);
    chk("new_seg", SEG, 8'hF8);

    // async clear in ON
    run_to(1, BLANK_CYC + 4, 16'h1237, 4'h0);
    pulse_clr();
    chk("clr_dig", DIG_EN, 4'hF);
    chk("clr_seg", SEG, 8'hFF);
    step(1'b1, 16'h1237, 4'h0);
    chk("clr_ce", RING_CE, 1);
    chk("clr_slot", SLOT, 0);

`ifdef LZB_EN
    run_to(3, BLANK_CYC, 16'h0050, 4'h0);
    chk("lzb_s3", SEG, 8'hFF);
    run_to(2, BLANK_CYC, 16'h0050, 4'h0);
    chk("lzb_s2", SEG, 8'hFF);
    run_to(1, BLANK_CYC, 16'h0050, 4'h0);
    chk("lzb_s1", SEG, 8'h92);
    run_to(0, BLANK_CYC, 16'h0050, 4'h0);
    chk("lzb_s0", SEG, 8'hC0);
    run_to(3, BLANK_CYC, 16'h0050, 4'h8);
    chk("lzb_dp3", SEG, 8'h7F);
    chk("lzb_dig3", DIG_EN, 4'b0111);
`else
    run_to(3, BLANK_CYC, 16'h0050, 4'h0);
    chk("nolzb_s3", SEG, 8'hC0);
    run_to(1, BLANK_CYC, 16'h0050, 4'h2);
    chk("nolzb_s1dp", SEG, 8'h12);
`endif

    // randomized traffic
    d = 16'h1234; p = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulse_clr();
      end else begin
        en = ($urandom_range(0, 39) != 0);
        if ($urandom_range(0, 7) == 0) begin
          d = rand_data();
          p = 4'($urandom);
        end
        step(en, d, p);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed 7-segment display scan controller for the countdown timer front panel. It sequences the digit ring counter by generating its clock-enable pulse at a fixed slot rate. It tracks the active digit internally in lockstep with the ring counter, inserts a dead-time blanking phase between digits, and drives registered segment outputs from the BCD/hex digit bus.

## Interface
- DIGITS, 4: number of multiplexed digits (≥2); digit 0 is least significant.
- PRESC, 1000: CLK cycles per digit slot (> BLANK_CYC).
- BLANK_CYC, 50: dead-time cycles at the start of each slot (≥2).
- ACT_STATE, 1'b0: active level of DIG_EN.
- SEG_ACT, 1'b0: active level of SEG.

Ports:
- CLK  in  1  clock.
- CLR  in  1  reset, asynchronous, active-high.
- EN  in  1  scan enable.
- DATA  in  4*DIGITS  digit codes; nibble i = DATA[4i+3:4i].
- DP  in  DIGITS  decimal point per digit.
- RING_CE  out  1  one-cycle advance pulse to the external ring counter CE.
- SLOT  out  $clog2(DIGITS)  index of the current digit.
- DIG_EN  out  DIGITS  one-hot digit enable at ACT_STATE level, else ~ACT_STATE.
- SEG  out  8  {dp,g,f,e,d,c,b,a} at SEG_ACT level.

## Operation
- States: IDLE, BLANK, ON. Slot counter cnt is $clog2(PRESC) bits wide.
- Reset values:
  - State is IDLE, cnt=0, SLOT=0, RING_CE=0.
  - DIG_EN={DIGITS{~ACT_STATE}}, SEG={8{~SEG_ACT}}.
  - The internal "started" flag is 0, mirroring the ring counter's all-inactive reset.
- IDLE → BLANK when EN=1.
  - On that transition: RING_CE pulses, cnt=0.
  - SLOT advances: 0 if started=0, else (SLOT+1) mod DIGITS. Started is then set to 1.
- BLANK:
  - All digits are off and SEG is off.
  - After BLANK_CYC cycles, go to ON.
- At BLANK → ON:
  - Capture nibble SLOT and DP[SLOT].
  - SEG = hex decode (0–F, standard a–g patterns) plus dp.
  - Assert DIG_EN[SLOT].
- ON:
  - Outputs are held.
  - After PRESC-BLANK_CYC cycles, go to BLANK: RING_CE pulses, SLOT wraps DIGITS-1 → 0.
- EN=0 in any state: next cycle goes to IDLE with all digits and segments off. SLOT and started are retained.
- DATA or DP changes during ON have no effect until the next slot.
- CLR mid-operation: immediate return to the reset values. Started clears, so the first slot after re-enable is 0, matching the ring counter, which also resets.
- Exactly one DIG_EN bit is active at any time, or none.

## Timing
- All outputs are registered.
- RING_CE is high only in the first cycle of each BLANK phase. The ring counter updates at the end of that cycle, so it is valid from the second BLANK cycle onward. This is why BLANK_CYC ≥ 2.
- Slot period is exactly PRESC cycles: BLANK_CYC blank plus PRESC-BLANK_CYC lit.
- Latency from EN rising to the first DIG_EN active is BLANK_CYC+1 cycles. The extra cycle is the registered IDLE exit.
- DATA-to-SEG latency is up to one slot period; DATA is sampled on the BLANK → ON edge.

## Configuration
- Macro: LZB_EN (leading-zero blanking).
- Defined: digit i>0 shows SEG={8{~SEG_ACT}} when all nibbles i..DIGITS-1 are 0 and DP[i]=0.
  - DIG_EN timing is unchanged.
  - Digit 0 is never blanked.
- Undefined: every digit is decoded normally.

## Test plan
Parameters for all scenarios: DIGITS=4, PRESC=10, BLANK_CYC=2, ACT_STATE=0, SEG_ACT=0.

- **Reset state:** assert CLR with EN=1 → DIG_EN=4'b1111, SEG=8'hFF, RING_CE=0. After release, the first RING_CE occurs one cycle later with SLOT=0. DIG_EN=4'b1110 appears 3 cycles after release.
- **Scan sequence:** EN=1, DATA=16'h1234 → RING_CE every 10 cycles.
  - SLOT sequence is 0,1,2,3,0.
  - DIG_EN is lit 8 cycles per slot, preceded by 2 blank cycles.
  - SEG for slot 0 is 8'b1001_1001 (digit "4", dp off).
- **EN gaps:**
  - EN dropped in slot 2 ON → all off next cycle, no RING_CE.
  - EN re-raised → RING_CE pulses and SLOT=3.
- **Data change mid-slot:** change DATA nibble 0 from 4 to 7 during slot 0 ON → SEG unchanged until slot 0 next comes round, then it shows "7".
- **Async reset mid-ON:** pulse CLR mid-ON → outputs return to reset values in the same cycle, and scanning restarts at SLOT=0.
- **Leading-zero blanking:** LZB_EN defined, DATA=16'h0050 → slots 3 and 2 have SEG=8'hFF, slot 1 shows "5", slot 0 shows "0". With DP[3]=1, slot 3 shows only dp (SEG=8'h7F).
